net_packet_rx: RTL and testbench
================================

Name: net_packet_rx

Overview:
- Core-side responder for the host network packet stream.
- Sits between the core's `net_packet_flat_i` port and its internal imem, register file, PC and barrier logic.
- Filters packets by ID, buffers them in a small FIFO, and decodes each packet into one-cycle write strobes.
- Runs a halt/run state machine that gates core execution until a PC packet arrives.

Parameters:
- `net_ID_p`, 10'b1, ID this core answers to; ID 10'b0 is also accepted as broadcast.
- `imem_addr_width_p`, `imem_addr_width_gp`, instruction memory address width.
- `fifo_depth_p`, 4, packet buffer entries; must be a power of 2 and at least 2.

Ports:
- `clk`  in  1  sole clock, all state on posedge
- `reset`  in  1  asynchronous, active-low reset
- `net_packet_flat_i`  in  `$bits(net_packet_s)`  incoming packet, sampled every posedge, no backpressure
- `rf_ready_i`  in  1  core register-file write port free this cycle
- `exception_i`  in  1  core exception; forces halt
- `imem_wen_o`  out  1  instruction write strobe
- `imem_waddr_o`  out  `imem_addr_width_p`  instruction address
- `imem_wdata_o`  out  16  instruction word (`net_data[15:0]`)
- `rf_wen_o`  out  1  register write strobe
- `rf_waddr_o`  out  `rs_imm_size_gp`  register index
- `rf_wdata_o`  out  32  register value
- `pc_wen_o`  out  1  PC load strobe
- `pc_value_o`  out  `imem_addr_width_p`  new PC (from `net_addr`)
- `barrier_wen_o`  out  1  barrier-bit load, issued with the PC packet
- `barrier_value_o`  out  `mask_length_gp`  `net_data[mask_length_gp-1:0]` of the PC packet
- `bar_mask_wen_o`  out  1  barrier mask load strobe
- `bar_mask_o`  out  `mask_length_gp`  `net_data[mask_length_gp-1:0]` of the BAR packet
- `run_o`  out  1  core execution enable
- `overflow_o`  out  1  sticky: a packet was dropped because the FIFO was full
- `drop_count_o`  out  16  count of dropped packets (overflow plus bad address), saturating

Behaviour:
- Reset (`reset`==0, asynchronous):
  - FIFO emptied; state HALT.
  - All strobes, `run_o`, `overflow_o` and `drop_count_o` at 0.
  - All data outputs at 0.
- Accept rule: a packet is enqueued at posedge when both hold:
  - its ID equals `net_ID_p` or 0;
  - `net_op` is not NULL.
- Any other packet is ignored silently and not counted.
- Enqueue while the FIFO is full is allowed only if a dequeue happens at the same edge. Otherwise the packet is dropped:
  - `overflow_o` is set and stays set until reset;
  - `drop_count_o` increments, saturating at 16'hFFFF.
- Dequeue: the FIFO head issues at posedge when the FIFO is non-empty and either:
  - the head op is not REG, or
  - the head op is REG and `rf_ready_i`==1.
- A stalled REG head blocks all later entries; packet order is always preserved.
- Issue: exactly one strobe, registered, high for one cycle in the cycle after the dequeue edge.
  - Data outputs hold their last issued value between strobes.
- Latency with an empty FIFO and ready targets: packet valid in cycle t, strobe visible in cycle t+2. Sustained rate is 1 packet/cycle.
- Decode:
  - INSTR: `imem_wen_o`. If `net_addr` has nonzero bits at or above `imem_addr_width_p`, no strobe is issued and `drop_count_o` increments.
  - REG: `rf_wen_o`, `rf_waddr_o`=`net_addr[rs_imm_size_gp-1:0]`. Upper address bits are ignored.
  - PC: `pc_wen_o` and `barrier_wen_o` assert in the same cycle.
  - BAR: `bar_mask_wen_o`.
- State machine:
  - HALT→RUN when a PC packet issues; `run_o`=1 from the same cycle as `pc_wen_o`.
  - RUN→RUN on a PC packet (re-vector).
  - RUN→HALT when `exception_i`=1 at posedge; `run_o` drops the next cycle.
  - If `exception_i` and a PC issue fall on the same edge, the exception wins: state stays or goes HALT, and `pc_wen_o` still fires.
  - INSTR, REG and BAR packets are accepted in both states.
- Mid-stream reset: in-flight FIFO entries are discarded, with no partial strobe.

Decomposition:
- Shared package (these are the existing definitions):
  - `net_packet_s`, `net_op` enum (NULL, INSTR, REG, PC, BAR);
  - `mask_length_gp`, `rs_imm_size_gp`, `imem_addr_width_gp`.
- New package constant: `net_broadcast_id_gp`=10'b0.
- Sub-module `net_packet_fifo`:
  - parameterised depth and width;
  - ports: `clk`, `reset`, `enq`, `deq`, `full`, `empty`, head data.
- The decode and state machine stay in `net_packet_rx`.

Test Plan:
- After reset, send INSTR ID=1 addr=5 data=16'h1A2B → `imem_wen_o` one cycle at t+2, `imem_waddr_o`=5, `imem_wdata_o`=16'h1A2B; `run_o`=0.
- Send REG addr=20 data=1 with `rf_ready_i`=0 for 3 cycles, then a BAR data=7 right behind it → no strobe while stalled. Once ready returns: `rf_wen_o` with `rf_waddr_o`=20 and `rf_wdata_o`=1, then `bar_mask_wen_o` one cycle later with `bar_mask_o`=3'b111.
- Send PC addr=0 data=2 → `pc_wen_o`, `pc_value_o`=0, `barrier_value_o`=3'b010, `run_o` rises the same cycle; then pulse `exception_i` → `run_o`=0 next cycle.
- Send ID=2 REG packets and a NULL packet → no strobes, `drop_count_o` unchanged.
- Hold `rf_ready_i`=0 and stream 6 REG packets with depth 4 → 4 queued, 2 dropped (`overflow_o`=1, `drop_count_o`=2). Release ready → exactly 4 `rf_wen_o` pulses in order.
- Send INSTR addr=10'h3FF with `imem_addr_width_p`=8 → no `imem_wen_o`, `drop_count_o`+1.
- Assert `reset` with 3 entries queued → all outputs 0 immediately, and no strobes after release.

Source files
------------

// File: rtl/net_packet_rx_pkg.sv
// Shared network packet definitions for the core-side packet responder.
// Field widths, opcodes and the buffered-entry layout live here.
package net_packet_rx_pkg;

    localparam int unsigned mask_length_gp     = 3;
    localparam int unsigned rs_imm_size_gp     = 5;
    localparam int unsigned imem_addr_width_gp = 8;
    localparam int unsigned net_id_width_gp    = 10;
    localparam int unsigned net_addr_width_gp  = 10;
    localparam int unsigned net_data_width_gp  = 32;

    localparam logic [net_id_width_gp-1:0] net_broadcast_id_gp = 10'b0;

    typedef enum logic [2:0] {
        NET_NULL  = 3'd0,
        NET_INSTR = 3'd1,
        NET_REG   = 3'd2,
        NET_PC    = 3'd3,
        NET_BAR   = 3'd4
    } net_op_e;

    typedef struct packed {
        logic [net_data_width_gp-1:0] net_data;
        logic [net_addr_width_gp-1:0] net_addr;
        net_op_e                      net_op;
        logic [net_id_width_gp-1:0]   net_id;
    } net_packet_s;

    // ID is consumed by the filter, so buffered entries drop it
    typedef struct packed {
        logic [net_data_width_gp-1:0] net_data;
        logic [net_addr_width_gp-1:0] net_addr;
        net_op_e                      net_op;
    } net_entry_s;

    typedef enum logic {
        RX_HALT = 1'b0,
        RX_RUN  = 1'b1
    } rx_state_e;

endpackage

// File: rtl/net_packet_fifo.sv
// Power-of-two circular packet buffer; head data is visible combinationally.
// Callers must not enqueue when full without a same-edge dequeue, nor dequeue when empty.
module net_packet_fifo #(
    parameter int unsigned depth_p = 4,
    parameter int unsigned width_p = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq,
    input  logic               deq,
    input  logic [width_p-1:0] data_i,
    output logic               full,
    output logic               empty,
    output logic [width_p-1:0] head_o
);

    localparam int unsigned ptr_w = $clog2(depth_p);

    logic [width_p-1:0] mem_q [depth_p];
    logic [ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ptr_w:0]     count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) wr_ptr_d = wr_ptr_q + ptr_w'(1);
        if (deq) rd_ptr_d = rd_ptr_q + ptr_w'(1);
        unique case ({enq, deq})
            2'b10:   count_d = count_q + (ptr_w + 1)'(1);
            2'b01:   count_d = count_q - (ptr_w + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only entries counted as valid are ever read
    always_ff @(posedge clk) begin
        if (enq) mem_q[wr_ptr_q] <= data_i;
    end

    assign full   = (count_q == (ptr_w + 1)'(depth_p));
    assign empty  = (count_q == '0);
    assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/net_packet_rx.sv
// Core-side packet responder: ID filter, packet buffer, one-cycle write-strobe
// decode and the halt/run state machine that gates core execution.
module net_packet_rx
    import net_packet_rx_pkg::*;
#(
    parameter logic [net_id_width_gp-1:0] net_ID_p          = 10'd1,
    parameter int unsigned                imem_addr_width_p = imem_addr_width_gp,
    parameter int unsigned                fifo_depth_p      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [$bits(net_packet_s)-1:0] net_packet_flat_i,
    input  logic                         rf_ready_i,
    input  logic                         exception_i,
    output logic                         imem_wen_o,
    output logic [imem_addr_width_p-1:0] imem_waddr_o,
    output logic [15:0]                  imem_wdata_o,
    output logic                         rf_wen_o,
    output logic [rs_imm_size_gp-1:0]    rf_waddr_o,
    output logic [31:0]                  rf_wdata_o,
    output logic                         pc_wen_o,
    output logic [imem_addr_width_p-1:0] pc_value_o,
    output logic                         barrier_wen_o,
    output logic [mask_length_gp-1:0]    barrier_value_o,
    output logic                         bar_mask_wen_o,
    output logic [mask_length_gp-1:0]    bar_mask_o,
    output logic                         run_o,
    output logic                         overflow_o,
    output logic [15:0]                  drop_count_o
);

    net_packet_s pkt;
    net_entry_s  in_entry, head;
    logic        accept, fifo_full, fifo_empty, enq, deq, drop_ovf, instr_bad;

    assign pkt      = net_packet_s'(net_packet_flat_i);
    assign in_entry = '{net_data: pkt.net_data, net_addr: pkt.net_addr, net_op: pkt.net_op};
    assign accept   = ((pkt.net_id == net_ID_p) || (pkt.net_id == net_broadcast_id_gp))
                      && (pkt.net_op != NET_NULL);

    // A REG head waits for the register-file port and blocks everything behind it
    assign deq       = !fifo_empty && ((head.net_op != NET_REG) || rf_ready_i);
    assign enq       = accept && (!fifo_full || deq);
    assign drop_ovf  = accept && fifo_full && !deq;
    assign instr_bad = deq && (head.net_op == NET_INSTR)
                       && ((head.net_addr >> imem_addr_width_p) != '0);

    net_packet_fifo #(
        .depth_p (fifo_depth_p),
        .width_p ($bits(net_entry_s))
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .enq    (enq),
        .deq    (deq),
        .data_i (in_entry),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .head_o (head)
    );

    rx_state_e                    state_q, state_d;
    logic                         imem_wen_q, imem_wen_d, rf_wen_q, rf_wen_d;
    logic                         pc_wen_q, pc_wen_d, barrier_wen_q, barrier_wen_d;
    logic                         bar_mask_wen_q, bar_mask_wen_d;
    logic [imem_addr_width_p-1:0] imem_waddr_q, imem_waddr_d, pc_value_q, pc_value_d;
    logic [15:0]                  imem_wdata_q, imem_wdata_d;
    logic [rs_imm_size_gp-1:0]    rf_waddr_q, rf_waddr_d;
    logic [31:0]                  rf_wdata_q, rf_wdata_d;
    logic [mask_length_gp-1:0]    barrier_value_q, barrier_value_d, bar_mask_q, bar_mask_d;
    logic                         overflow_q, overflow_d;
    logic [15:0]                  drop_count_q, drop_count_d;
    logic [1:0]                   drop_inc;
    logic [16:0]                  drop_sum;

    // Decode the issuing head into strobes; data outputs hold between strobes
    always_comb begin
        state_d         = state_q;
        imem_wen_d      = 1'b0;
        rf_wen_d        = 1'b0;
        pc_wen_d        = 1'b0;
        barrier_wen_d   = 1'b0;
        bar_mask_wen_d  = 1'b0;
        imem_waddr_d    = imem_waddr_q;
        imem_wdata_d    = imem_wdata_q;
        rf_waddr_d      = rf_waddr_q;
        rf_wdata_d      = rf_wdata_q;
        pc_value_d      = pc_value_q;
        barrier_value_d = barrier_value_q;
        bar_mask_d      = bar_mask_q;
        if (deq) begin
            unique case (head.net_op)
                NET_INSTR: begin
                    if (!instr_bad) begin
                        imem_wen_d   = 1'b1;
                        imem_waddr_d = imem_addr_width_p'(head.net_addr);
                        imem_wdata_d = head.net_data[15:0];
                    end
                end
                NET_REG: begin
                    rf_wen_d   = 1'b1;
                    rf_waddr_d = head.net_addr[rs_imm_size_gp-1:0];
                    rf_wdata_d = head.net_data;
                end
                NET_PC: begin
                    pc_wen_d        = 1'b1;
                    barrier_wen_d   = 1'b1;
                    pc_value_d      = imem_addr_width_p'(head.net_addr);
                    barrier_value_d = head.net_data[mask_length_gp-1:0];
                    state_d         = RX_RUN;
                end
                NET_BAR: begin
                    bar_mask_wen_d = 1'b1;
                    bar_mask_d     = head.net_data[mask_length_gp-1:0];
                end
                default: ;
            endcase
        end
        // Exception outranks a same-edge PC load
        if (exception_i) state_d = RX_HALT;

        overflow_d   = overflow_q | drop_ovf;
        drop_inc     = 2'(drop_ovf) + 2'(instr_bad);
        drop_sum     = 17'(drop_count_q) + 17'(drop_inc);
        drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= RX_HALT;
            imem_wen_q      <= 1'b0;
            rf_wen_q        <= 1'b0;
            pc_wen_q        <= 1'b0;
            barrier_wen_q   <= 1'b0;
            bar_mask_wen_q  <= 1'b0;
            imem_waddr_q    <= '0;
            imem_wdata_q    <= '0;
            rf_waddr_q      <= '0;
            rf_wdata_q      <= '0;
            pc_value_q      <= '0;
            barrier_value_q <= '0;
            bar_mask_q      <= '0;
            overflow_q      <= 1'b0;
            drop_count_q    <= '0;
        end else begin
            state_q         <= state_d;
            imem_wen_q      <= imem_wen_d;
            rf_wen_q        <= rf_wen_d;
            pc_wen_q        <= pc_wen_d;
            barrier_wen_q   <= barrier_wen_d;
            bar_mask_wen_q  <= bar_mask_wen_d;
            imem_waddr_q    <= imem_waddr_d;
            imem_wdata_q    <= imem_wdata_d;
            rf_waddr_q      <= rf_waddr_d;
            rf_wdata_q      <= rf_wdata_d;
            pc_value_q      <= pc_value_d;
            barrier_value_q <= barrier_value_d;
            bar_mask_q      <= bar_mask_d;
            overflow_q      <= overflow_d;
            drop_count_q    <= drop_count_d;
        end
    end

    assign imem_wen_o      = imem_wen_q;
    assign imem_waddr_o    = imem_waddr_q;
    assign imem_wdata_o    = imem_wdata_q;
    assign rf_wen_o        = rf_wen_q;
    assign rf_waddr_o      = rf_waddr_q;
    assign rf_wdata_o      = rf_wdata_q;
    assign pc_wen_o        = pc_wen_q;
    assign pc_value_o      = pc_value_q;
    assign barrier_wen_o   = barrier_wen_q;
    assign barrier_value_o = barrier_value_q;
    assign bar_mask_wen_o  = bar_mask_wen_q;
    assign bar_mask_o      = bar_mask_q;
    assign run_o           = (state_q == RX_RUN);
    assign overflow_o      = overflow_q;
    assign drop_count_o    = drop_count_q;

endmodule

// File: tb/tb_net_packet_rx.sv
// Directed bench for net_packet_rx: a table of single-packet vectors plus
// hand-written sequences for stalls, run/halt, overflow and mid-stream reset.
module tb_net_packet_rx;
    import net_packet_rx_pkg::*;

    logic                            clk;
    logic                            reset;
    logic [$bits(net_packet_s)-1:0]  net_packet_flat_i;
    logic                            rf_ready_i;
    logic                            exception_i;
    logic                            imem_wen_o;
    logic [7:0]                      imem_waddr_o;
    logic [15:0]                     imem_wdata_o;
    logic                            rf_wen_o;
    logic [4:0]                      rf_waddr_o;
    logic [31:0]                     rf_wdata_o;
    logic                            pc_wen_o;
    logic [7:0]                      pc_value_o;
    logic                            barrier_wen_o;
    logic [2:0]                      barrier_value_o;
    logic                            bar_mask_wen_o;
    logic [2:0]                      bar_mask_o;
    logic                            run_o;
    logic                            overflow_o;
    logic [15:0]                     drop_count_o;

    net_packet_rx #(
        .net_ID_p          (10'd1),
        .imem_addr_width_p (8),
        .fifo_depth_p      (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .net_packet_flat_i (net_packet_flat_i),
        .rf_ready_i        (rf_ready_i),
        .exception_i       (exception_i),
        .imem_wen_o        (imem_wen_o),
        .imem_waddr_o      (imem_waddr_o),
        .imem_wdata_o      (imem_wdata_o),
        .rf_wen_o          (rf_wen_o),
        .rf_waddr_o        (rf_waddr_o),
        .rf_wdata_o        (rf_wdata_o),
        .pc_wen_o          (pc_wen_o),
        .pc_value_o        (pc_value_o),
        .barrier_wen_o     (barrier_wen_o),
        .barrier_value_o   (barrier_value_o),
        .bar_mask_wen_o    (bar_mask_wen_o),
        .bar_mask_o        (bar_mask_o),
        .run_o             (run_o),
        .overflow_o        (overflow_o),
        .drop_count_o      (drop_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  id;
        net_op_e     op;
        logic [9:0]  addr;
        logic [31:0] data;
        logic [3:0]  exp_stb;   // {imem, rf, pc, bar_mask}
        logic [7:0]  exp_iaddr;
        logic [15:0] exp_idata;
        logic [4:0]  exp_raddr;
        logic [31:0] exp_rdata;
        logic [2:0]  exp_bar;
        logic [15:0] exp_drop;
    } vec_t;

    vec_t vecs [6];
    int   total = 0;
    int   bad   = 0;

    function automatic net_packet_s mk(logic [9:0] id, net_op_e op, logic [9:0] addr, logic [31:0] data);
        net_packet_s p;
        p.net_id   = id;
        p.net_op   = op;
        p.net_addr = addr;
        p.net_data = data;
        return p;
    endfunction

    function automatic logic [3:0] stb();
        return {imem_wen_o, rf_wen_o, pc_wen_o, bar_mask_wen_o};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        net_packet_flat_i = mk(10'd0, NET_NULL, 10'd0, 32'd0);
    endtask

    initial begin
        vecs[0] = '{10'd1, NET_INSTR, 10'd5,     32'h0000_1A2B, 4'b1000, 8'd5, 16'h1A2B, 5'd0,  32'h0,         3'd0, 16'd0};
        vecs[1] = '{10'd0, NET_REG,   10'h3F4,   32'hDEAD_BEEF, 4'b0100, 8'd5, 16'h1A2B, 5'd20, 32'hDEAD_BEEF, 3'd0, 16'd0};
        vecs[2] = '{10'd2, NET_INSTR, 10'd7,     32'h0000_5555, 4'b0000, 8'd5, 16'h1A2B, 5'd20, 32'hDEAD_BEEF, 3'd0, 16'd0};
        vecs[3] = '{10'd1, NET_NULL,  10'd3,     32'h0000_0001, 4'b0000, 8'd5, 16'h1A2B, 5'd20, 32'hDEAD_BEEF, 3'd0, 16'd0};
        vecs[4] = '{10'd1, NET_BAR,   10'd0,     32'h0000_0006, 4'b0001, 8'd5, 16'h1A2B, 5'd20, 32'hDEAD_BEEF, 3'd6, 16'd0};
        vecs[5] = '{10'd1, NET_INSTR, 10'h3FF,   32'h0000_9999, 4'b0000, 8'd5, 16'h1A2B, 5'd20, 32'hDEAD_BEEF, 3'd6, 16'd1};

        reset       = 1'b0;
        rf_ready_i  = 1'b1;
        exception_i = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stb", 32'(stb()), 32'd0);
        chk("rst_run", 32'(run_o), 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        chk("rst_drop", 32'(drop_count_o), 32'd0);
        chk("rst_iaddr", 32'(imem_waddr_o), 32'd0);
        reset = 1'b1;
        tick();

        // Single packets into an empty buffer: strobe two edges after valid
        for (int i = 0; i < 6; i++) begin
            net_packet_flat_i = mk(vecs[i].id, vecs[i].op, vecs[i].addr, vecs[i].data);
            tick();
            idle();
            tick();
            chk($sformatf("v%0d_stb", i), 32'(stb()), 32'(vecs[i].exp_stb));
            chk($sformatf("v%0d_iaddr", i), 32'(imem_waddr_o), 32'(vecs[i].exp_iaddr));
            chk($sformatf("v%0d_idata", i), 32'(imem_wdata_o), 32'(vecs[i].exp_idata));
            chk($sformatf("v%0d_raddr", i), 32'(rf_waddr_o), 32'(vecs[i].exp_raddr));
            chk($sformatf("v%0d_rdata", i), rf_wdata_o, vecs[i].exp_rdata);
            chk($sformatf("v%0d_bar", i), 32'(bar_mask_o), 32'(vecs[i].exp_bar));
            chk($sformatf("v%0d_drop", i), 32'(drop_count_o), 32'(vecs[i].exp_drop));
            chk($sformatf("v%0d_run", i), 32'(run_o), 32'd0);
            tick();
            chk($sformatf("v%0d_stb_off", i), 32'(stb()), 32'd0);
        end

        // Stalled REG head blocks the BAR queued behind it
        rf_ready_i = 1'b0;
        net_packet_flat_i = mk(10'd1, NET_REG, 10'd20, 32'd1);
        tick();
        net_packet_flat_i = mk(10'd1, NET_BAR, 10'd0, 32'd7);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall%0d_stb", i), 32'(stb()), 32'd0);
            tick();
        end
        rf_ready_i = 1'b1;
        tick();
        chk("stall_rf_stb", 32'(stb()), 32'b0100);
        chk("stall_rf_addr", 32'(rf_waddr_o), 32'd20);
        chk("stall_rf_data", rf_wdata_o, 32'd1);
        tick();
        chk("stall_bar_stb", 32'(stb()), 32'b0001);
        chk("stall_bar_mask", 32'(bar_mask_o), 32'd7);
        tick();
        chk("stall_after_stb", 32'(stb()), 32'd0);

        // PC starts the core; exception halts it one cycle later
        net_packet_flat_i = mk(10'd1, NET_PC, 10'd0, 32'd2);
        tick();
        idle();
        tick();
        chk("pc_stb", 32'(stb()), 32'b0010);
        chk("pc_bwen", 32'(barrier_wen_o), 32'd1);
        chk("pc_value", 32'(pc_value_o), 32'd0);
        chk("pc_barrier", 32'(barrier_value_o), 32'd2);
        chk("pc_run", 32'(run_o), 32'd1);
        tick();
        chk("pc_off_stb", 32'(stb()), 32'd0);
        chk("pc_off_bwen", 32'(barrier_wen_o), 32'd0);
        chk("pc_run_hold", 32'(run_o), 32'd1);
        exception_i = 1'b1;
        tick();
        exception_i = 1'b0;
        chk("exc_run", 32'(run_o), 32'd0);
        tick();
        chk("exc_run_hold", 32'(run_o), 32'd0);

        // Re-enter RUN, then exception on the same edge as the next PC issue
        net_packet_flat_i = mk(10'd1, NET_PC, 10'd3, 32'd0);
        tick();
        idle();
        tick();
        chk("pc2_run", 32'(run_o), 32'd1);
        chk("pc2_value", 32'(pc_value_o), 32'd3);
        net_packet_flat_i = mk(10'd1, NET_PC, 10'd9, 32'd5);
        tick();
        idle();
        exception_i = 1'b1;
        tick();
        exception_i = 1'b0;
        chk("pcexc_stb", 32'(stb()), 32'b0010);
        chk("pcexc_value", 32'(pc_value_o), 32'd9);
        chk("pcexc_barrier", 32'(barrier_value_o), 32'd5);
        chk("pcexc_run", 32'(run_o), 32'd0);

        // Foreign IDs and NULL ops are ignored and not counted
        net_packet_flat_i = mk(10'd2, NET_REG, 10'd1, 32'd11);
        tick();
        net_packet_flat_i = mk(10'd2, NET_REG, 10'd2, 32'd12);
        tick();
        net_packet_flat_i = mk(10'd1, NET_NULL, 10'd3, 32'd13);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ign%0d_stb", i), 32'(stb()), 32'd0);
            chk($sformatf("ign%0d_drop", i), 32'(drop_count_o), 32'd1);
            tick();
        end

        // Six REG packets into a depth-4 buffer with the register port busy
        rf_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            net_packet_flat_i = mk(10'd1, NET_REG, 10'(i + 1), 32'(100 + i));
            tick();
        end
        idle();
        chk("ovf_flag", 32'(overflow_o), 32'd1);
        chk("ovf_drop", 32'(drop_count_o), 32'd3);
        chk("ovf_stb", 32'(stb()), 32'd0);
        rf_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("ovf%0d_rf_wen", i), 32'(rf_wen_o), 32'd1);
            chk($sformatf("ovf%0d_rf_addr", i), 32'(rf_waddr_o), 32'(i + 1));
            chk($sformatf("ovf%0d_rf_data", i), rf_wdata_o, 32'(100 + i));
        end
        tick();
        chk("ovf_done_stb", 32'(stb()), 32'd0);
        chk("ovf_sticky", 32'(overflow_o), 32'd1);

        // Reset with entries queued clears outputs at once and discards the queue
        rf_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            net_packet_flat_i = mk(10'd1, NET_REG, 10'(7 + i), 32'(i));
            tick();
        end
        idle();
        tick();
        reset = 1'b0;
        #1;
        chk("mrst_stb", 32'(stb()), 32'd0);
        chk("mrst_run", 32'(run_o), 32'd0);
        chk("mrst_ovf", 32'(overflow_o), 32'd0);
        chk("mrst_drop", 32'(drop_count_o), 32'd0);
        chk("mrst_raddr", 32'(rf_waddr_o), 32'd0);
        chk("mrst_rdata", rf_wdata_o, 32'd0);
        chk("mrst_iaddr", 32'(imem_waddr_o), 32'd0);
        chk("mrst_pcval", 32'(pc_value_o), 32'd0);
        chk("mrst_bar", 32'(bar_mask_o), 32'd0);
        tick();
        tick();
        reset      = 1'b1;
        rf_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("post_rst%0d_stb", i), 32'(stb()), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
